// File: rtl/loc_stack_replay.sv
// ---------------------------------------------------------------------------
// loc_stack_replay
//
// Location buffer for the path-search datapath. In STACK mode it is a LIFO
// used while backtracking. A one-cycle done pulse switches it to REPLAY mode,
// where the stored path is read from the bottom up (FIFO order). Replay uses a
// separate read pointer, so the top-of-stack count is left unchanged.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       synchronous, active-high reset
//   i_clr       synchronous soft clear, same effect as reset
//   i_push      write i_loc_in (STACK mode only)
//   i_pop       read one entry (top in STACK, next-from-bottom in REPLAY)
//   i_done      one-cycle pulse that enters (or restarts) REPLAY
//   i_loc_in    location to push
//   o_loc_out   registered read data
//   o_out_vld   one-cycle strobe, o_loc_out was updated this cycle
//   o_emp_stck  STACK: count==0, REPLAY: rd_ptr==count
//   o_full      count==DEPTH in STACK mode, 0 in REPLAY
//   o_count     entries held (top pointer)
//   o_mode      0=STACK, 1=REPLAY
//   o_err       sticky illegal push/pop flag, cleared by rst/clr
// ---------------------------------------------------------------------------
module loc_stack_replay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_done,
  input  logic [WIDTH-1:0] i_loc_in,
  output logic [WIDTH-1:0] o_loc_out,
  output logic          o_out_vld,
  output logic          o_emp_stck,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_mode,
  output logic          o_err
);

  typedef enum logic {StStack, StReplay} mode_e;

  localparam logic [AW:0] DepthP = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneP   = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_count;
  logic [AW:0]      r_rd_ptr;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_loc_out;
  logic             r_out_vld;
  logic             r_err;

  logic [AW:0]      w_count_d;
  logic [AW:0]      w_rd_ptr_d;
  mode_e            w_mode_d;
  logic             w_err_d;
  logic             w_err_set;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;

  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_cnt_idx;
  logic [AW-1:0]    w_rdp_idx;
  logic             w_empty_stk;
  logic             w_full_stk;
  logic             w_replay_end;

  // Address views of the pointers. Out-of-range values are only produced in
  // cases where the access is blocked, so truncation is harmless.
  assign w_top_idx    = AW'(r_count - OneP);
  assign w_cnt_idx    = AW'(r_count);
  assign w_rdp_idx    = AW'(r_rd_ptr);
  assign w_empty_stk  = (r_count == '0);
  assign w_full_stk   = (r_count == DepthP);
  assign w_replay_end = (r_rd_ptr >= r_count);

  // Next-state and command decode
  always_comb begin
    w_count_d  = r_count;
    w_rd_ptr_d = r_rd_ptr;
    w_mode_d   = r_mode;
    w_err_set  = 1'b0;
    w_we       = 1'b0;
    w_waddr    = w_cnt_idx;
    w_rd_en    = 1'b0;
    w_rd_addr  = w_top_idx;

    if (i_clr) begin
      w_count_d  = '0;
      w_rd_ptr_d = '0;
      w_mode_d   = StStack;
    end else if (i_done) begin
      // Any push/pop alongside done is discarded
      w_mode_d   = StReplay;
      w_rd_ptr_d = '0;
    end else if (r_mode == StStack) begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (w_full_stk) begin
            w_err_set = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_waddr   = w_cnt_idx;
            w_count_d = r_count + OneP;
          end
        end
        2'b01: begin
          if (w_empty_stk) begin
            w_err_set = 1'b1;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_top_idx;
            w_count_d = r_count - OneP;
          end
        end
        2'b11: begin
          if (w_empty_stk) begin
            w_we      = 1'b1;
            w_waddr   = w_cnt_idx;
            w_count_d = r_count + OneP;
          end else begin
            // Swap the top: the read sees the old value, the write lands after
            w_rd_en   = 1'b1;
            w_rd_addr = w_top_idx;
            w_we      = 1'b1;
            w_waddr   = w_top_idx;
          end
        end
        default: ;
      endcase
    end else begin
      if (i_push) begin
        w_err_set = 1'b1;
      end
      if (i_pop) begin
        if (w_replay_end) begin
          w_err_set = 1'b1;
        end else begin
          w_rd_en    = 1'b1;
          w_rd_addr  = w_rdp_idx;
          w_rd_ptr_d = r_rd_ptr + OneP;
        end
      end
    end

    w_err_d = i_clr ? 1'b0 : (r_err | w_err_set);
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_mode    <= StStack;
      r_loc_out <= '0;
      r_out_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_count   <= w_count_d;
      r_rd_ptr  <= w_rd_ptr_d;
      r_mode    <= w_mode_d;
      r_out_vld <= w_rd_en;
      r_err     <= w_err_d;
      if (i_clr) begin
        r_loc_out <= '0;
      end else if (w_rd_en) begin
        r_loc_out <= r_mem[w_rd_addr];
      end
    end
  end

  // Storage array, no reset so it can map onto RAM
  always_ff @(posedge i_clk) begin
    if (w_we && !i_rst) begin
      r_mem[w_waddr] <= i_loc_in;
    end
  end

  assign o_loc_out  = r_loc_out;
  assign o_out_vld  = r_out_vld;
  assign o_count    = r_count;
  assign o_mode     = (r_mode == StReplay);
  assign o_err      = r_err;
  assign o_emp_stck = (r_mode == StReplay) ? (r_rd_ptr == r_count) : w_empty_stk;
  assign o_full     = (r_mode == StStack) && w_full_stk;

endmodule

// File: tb/tb_loc_stack_replay.sv
module tb_loc_stack_replay;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned A = $clog2(D);

  logic         clk;
  logic         rst, clr, push, pop, done;
  logic [W-1:0] loc_in;
  logic [W-1:0] loc_out;
  logic         out_vld, emp_stck, full, mode, err;
  logic [A:0]   count;

  loc_stack_replay #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (clr),
    .i_push     (push),
    .i_pop      (pop),
    .i_done     (done),
    .i_loc_in   (loc_in),
    .o_loc_out  (loc_out),
    .o_out_vld  (out_vld),
    .o_emp_stck (emp_stck),
    .o_full     (full),
    .o_count    (count),
    .o_mode     (mode),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of inputs and the outputs expected just after that edge
  typedef struct {
    logic         rst, clr, push, pop, done;
    logic [W-1:0] din;
    logic [W-1:0] lo;
    logic         vld, emp, full;
    logic [A:0]   cnt;
    logic         mode, err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic c, input logic pu, input logic po,
                              input logic dn, input logic [W-1:0] di, input logic [W-1:0] lo,
                              input logic vl, input logic em, input logic fu,
                              input logic [A:0] cn, input logic md, input logic er);
    vec_t v;
    v.rst = r; v.clr = c; v.push = pu; v.pop = po; v.done = dn; v.din = di;
    v.lo = lo; v.vld = vl; v.emp = em; v.full = fu; v.cnt = cn; v.mode = md; v.err = er;
    return v;
  endfunction

  // Called at a negedge: drive, clock, then sample 1 time unit after the edge
  task automatic apply(input vec_t v, input string name);
    rst = v.rst; clr = v.clr; push = v.push; pop = v.pop; done = v.done; loc_in = v.din;
    @(posedge clk);
    #1;
    n_vec++;
    if (loc_out !== v.lo || out_vld !== v.vld || emp_stck !== v.emp || full !== v.full ||
        count !== v.cnt || mode !== v.mode || err !== v.err) begin
      n_fail++;
      $display("FAIL %s: got lo=%h vld=%b emp=%b full=%b cnt=%0d mode=%b err=%b, want lo=%h vld=%b emp=%b full=%b cnt=%0d mode=%b err=%b",
               name, loc_out, out_vld, emp_stck, full, count, mode, err,
               v.lo, v.vld, v.emp, v.full, v.cnt, v.mode, v.err);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; done = 1'b0; loc_in = '0;

    //                 rst clr psh pop dn  din    lo     vld emp ful cnt mode err
    // Reset, then LIFO order
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h12, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h34, 8'h00, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h56, 8'h00, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h56, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h34, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h12, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h12, 0, 1, 0, 0, 0, 0));
    // Fill to DEPTH, overflow, swap while full, clr
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h01, 8'h12, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h02, 8'h12, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h03, 8'h12, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h04, 8'h12, 0, 0, 1, 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h05, 8'h12, 0, 0, 1, 4, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h44, 8'h04, 1, 0, 1, 4, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h44, 1, 0, 0, 3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0));
    // Underflow is flagged, loc_out held
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0));
    // Replay in FIFO order, over-read, restart with done
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'hA1, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'hB2, 8'h00, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'hC3, 8'h00, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hA1, 1, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hB2, 1, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hC3, 1, 1, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hC3, 0, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'hC3, 0, 0, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hA1, 1, 0, 0, 3, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0));
    // Push&pop swap on a non-empty stack, push&pop on empty acts as push
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h11, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h22, 8'h00, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h99, 8'h22, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h99, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h11, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h77, 8'h11, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h77, 1, 1, 0, 0, 0, 0));
    // done wins over push; push in REPLAY flagged; pop still runs with push
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h55, 8'h77, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h66, 8'h77, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h55, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h88, 8'h55, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h55, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h88, 8'h55, 1, 1, 0, 1, 1, 1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-replay, with a pop in the same cycle: reset wins
    apply(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0), "seq_clr");
    apply(mk(0, 0, 1, 0, 0, 8'h31, 8'h00, 0, 0, 0, 1, 0, 0), "seq_push1");
    apply(mk(0, 0, 1, 0, 0, 8'h32, 8'h00, 0, 0, 0, 2, 0, 0), "seq_push2");
    apply(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 2, 1, 0), "seq_done");
    apply(mk(0, 0, 0, 1, 0, 8'h00, 8'h31, 1, 0, 0, 2, 1, 0), "seq_pop_rd1");
    apply(mk(1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0), "seq_rst_mid");
    apply(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0), "seq_after_rst");

    // clr beats done in the same cycle
    apply(mk(0, 0, 1, 0, 0, 8'h41, 8'h00, 0, 0, 0, 1, 0, 0), "seq_push3");
    apply(mk(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0), "seq_clr_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

endmodule
